vram_arbiter: RTL and testbench

Shares the single synchronous video/tile RAM between the scanline fetch engine and the CPU bus. The fetch engine gets fixed priority and a bounded 3-cycle worst-case latency, so raster timing stays deterministic. CPU reads and writes are served in the remaining slots through a req/ack handshake. The block sits between the video fetcher, the CPU memory decoder and the RAM macro, and owns the RAM's address, write-data and write-enable pins.

---
 rtl/vram_arb_pkg.sv | 17 +
 rtl/vram_arbiter.sv | 126 ++++++++++++
 tb/tb_vram_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arb_pkg.sv
// Shared definitions for the video RAM arbiter: FSM states and default
// address width / write-protect boundary.
package vram_arb_pkg;

   localparam int unsigned C_ADDR_W   = 16;
   // Base of the tile/index region; CPU writes below it are refused.
   localparam logic [15:0] C_WP_LIMIT = 16'h4000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_VID_ISSUE,
      S_VID_WAIT,
      S_CPU_ISSUE,
      S_CPU_WAIT
   } state_t;

endpackage

// File: rtl/vram_arbiter.sv
// Arbiter for the single synchronous video/tile RAM. The scanline fetcher has
// fixed priority with a worst-case 3-cycle latency; CPU accesses fill the
// remaining slots through a req/ack handshake.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// S_IDLE      | no access in flight; video or CPU may be granted
// S_VID_ISSUE | RAM samples the video address
// S_VID_WAIT  | video read data on I_mem_rdata; next video may be granted
// S_CPU_ISSUE | RAM samples the CPU address (and write, if enabled)
// S_CPU_WAIT  | CPU read data on I_mem_rdata; only video may be granted next
module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int unsigned           P_addr_w   = C_ADDR_W,
   parameter logic [P_addr_w-1:0]   P_wp_limit = P_addr_w'(C_WP_LIMIT)
) (
   input  logic                I_clock,
   input  logic                I_reset,
   input  logic                I_vid_req,
   input  logic [P_addr_w-1:0] I_vid_addr,
   output logic                O_vid_valid,
   output logic [7:0]          O_vid_data,
   output logic                O_vid_overrun,
   input  logic                I_cpu_req,
   input  logic                I_cpu_we,
   input  logic [P_addr_w-1:0] I_cpu_addr,
   input  logic [7:0]          I_cpu_wdata,
   output logic                O_cpu_ack,
   output logic [7:0]          O_cpu_rdata,
   output logic                O_cpu_wp_err,
   output logic [P_addr_w-1:0] O_mem_addr,
   output logic                O_mem_we,
   output logic [7:0]          O_mem_wdata,
   input  logic [7:0]          I_mem_rdata
);

   state_t              r_state;
   logic                r_vid_pend;
   logic [P_addr_w-1:0] r_vid_pend_addr;
   logic                r_cpu_we;
   logic                r_cpu_blk;

   logic                w_vid_src;
   logic [P_addr_w-1:0] w_vid_addr;
   logic                w_cpu_blk;
   logic                w_arb;

   // A fresh request supersedes whatever is pending.
   assign w_vid_src  = I_vid_req | r_vid_pend;
   assign w_vid_addr = I_vid_req ? I_vid_addr : r_vid_pend_addr;
   assign w_cpu_blk  = (I_cpu_addr < P_wp_limit);
   assign w_arb      = (r_state == S_IDLE) || (r_state == S_VID_WAIT) ||
                       (r_state == S_CPU_WAIT);

   // Arbitration FSM with registered RAM pins and requester outputs.
   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
         r_state         <= S_IDLE;
         r_vid_pend      <= 1'b0;
         r_vid_pend_addr <= '0;
         r_cpu_we        <= 1'b0;
         r_cpu_blk       <= 1'b0;
         O_vid_valid     <= 1'b0;
         O_vid_data      <= 8'h00;
         O_vid_overrun   <= 1'b0;
         O_cpu_ack       <= 1'b0;
         O_cpu_rdata     <= 8'h00;
         O_cpu_wp_err    <= 1'b0;
         O_mem_addr      <= '0;
         O_mem_we        <= 1'b0;
         O_mem_wdata     <= 8'h00;
      end else begin
         O_vid_valid  <= 1'b0;
         O_cpu_ack    <= 1'b0;
         O_cpu_wp_err <= 1'b0;
         O_mem_we     <= 1'b0;

         if (I_vid_req && r_vid_pend) begin
            O_vid_overrun <= 1'b1;
         end

         case (r_state)
            S_VID_ISSUE, S_CPU_ISSUE: begin
               r_state <= (r_state == S_VID_ISSUE) ? S_VID_WAIT : S_CPU_WAIT;
               if (I_vid_req) begin
                  r_vid_pend      <= 1'b1;
                  r_vid_pend_addr <= I_vid_addr;
               end
            end
            S_VID_WAIT: begin
               O_vid_valid <= 1'b1;
               O_vid_data  <= I_mem_rdata;
            end
            S_CPU_WAIT: begin
               O_cpu_ack    <= 1'b1;
               O_cpu_wp_err <= r_cpu_blk;
               if (!r_cpu_we) begin
                  O_cpu_rdata <= I_mem_rdata;
               end
            end
            default: ;
         endcase

         if (w_arb) begin
            if (w_vid_src) begin
               O_mem_addr <= w_vid_addr;
               r_vid_pend <= 1'b0;
               r_state    <= S_VID_ISSUE;
            end else if (I_cpu_req && (r_state == S_IDLE) && !O_cpu_ack) begin
               // O_cpu_ack high here means the requester may not have seen
               // the previous ack yet, so the level is not a new request.
               O_mem_addr  <= I_cpu_addr;
               O_mem_wdata <= I_cpu_wdata;
               O_mem_we    <= I_cpu_we & ~w_cpu_blk;
               r_cpu_we    <= I_cpu_we;
               r_cpu_blk   <= I_cpu_we & w_cpu_blk;
               r_state     <= S_CPU_ISSUE;
            end else begin
               r_state <= S_IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous RAM.
module tb_vram_arbiter;

   logic        clk;
   logic        rst_b;
   logic        vid_req;
   logic [15:0] vid_addr;
   logic        vid_valid;
   logic [7:0]  vid_data;
   logic        vid_overrun;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic        cpu_wp_err;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   logic [7:0]  ram [0:65535];

   int vectors;
   int miscompares;

   vram_arbiter #(.P_addr_w(16), .P_wp_limit(16'h4000)) dut (
      .I_clock      (clk),
      .I_reset      (rst_b),
      .I_vid_req    (vid_req),
      .I_vid_addr   (vid_addr),
      .O_vid_valid  (vid_valid),
      .O_vid_data   (vid_data),
      .O_vid_overrun(vid_overrun),
      .I_cpu_req    (cpu_req),
      .I_cpu_we     (cpu_we),
      .I_cpu_addr   (cpu_addr),
      .I_cpu_wdata  (cpu_wdata),
      .O_cpu_ack    (cpu_ack),
      .O_cpu_rdata  (cpu_rdata),
      .O_cpu_wp_err (cpu_wp_err),
      .O_mem_addr   (mem_addr),
      .O_mem_we     (mem_we),
      .O_mem_wdata  (mem_wdata),
      .I_mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM: read data appears the cycle after the address is sampled.
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_addr"},    mem_addr, 16'h0000);
      chk({tag, "_we"},      16'(mem_we), 16'h0);
      chk({tag, "_wdata"},   16'(mem_wdata), 16'h0);
      chk({tag, "_vvalid"},  16'(vid_valid), 16'h0);
      chk({tag, "_vdata"},   16'(vid_data), 16'h0);
      chk({tag, "_overrun"}, 16'(vid_overrun), 16'h0);
      chk({tag, "_ack"},     16'(cpu_ack), 16'h0);
      chk({tag, "_rdata"},   16'(cpu_rdata), 16'h0);
      chk({tag, "_wperr"},   16'(cpu_wp_err), 16'h0);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_b = 1'b0;
      vid_req = 1'b0; vid_addr = 16'h0000;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
      ram[16'h4800] = 8'hA5;
      ram[16'h1000] = 8'h77;
      ram[16'h6000] = 8'h5A;
      ram[16'h5000] = 8'h00;
      #2;
      chk_all_zero("reset");
      step(); step();
      rst_b = 1'b1;

      // Single video fetch from idle: valid two edges after the request.
      vid_req = 1'b1; vid_addr = 16'h4800;
      step();
      vid_req = 1'b0;
      chk("v1_addr", mem_addr, 16'h4800);
      chk("v1_we", 16'(mem_we), 16'h0);
      chk("v1_valid_e0", 16'(vid_valid), 16'h0);
      step();
      chk("v1_valid_e1", 16'(vid_valid), 16'h0);
      step();
      chk("v1_valid_e2", 16'(vid_valid), 16'h1);
      chk("v1_data", 16'(vid_data), 16'h00A5);
      step();
      chk("v1_valid_e3", 16'(vid_valid), 16'h0);
      chk("v1_data_hold", 16'(vid_data), 16'h00A5);

      // CPU write 0x5000 = 0x3C.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h5000; cpu_wdata = 8'h3C;
      step();
      chk("w_we_grant", 16'(mem_we), 16'h1);
      chk("w_addr", mem_addr, 16'h5000);
      chk("w_wdata", 16'(mem_wdata), 16'h003C);
      chk("w_ack_e0", 16'(cpu_ack), 16'h0);
      step();
      chk("w_we_e1", 16'(mem_we), 16'h0);
      chk("w_ack_e1", 16'(cpu_ack), 16'h0);
      step();
      chk("w_ack_e2", 16'(cpu_ack), 16'h1);
      chk("w_wperr", 16'(cpu_wp_err), 16'h0);
      chk("w_ram", 16'(ram[16'h5000]), 16'h003C);
      cpu_req = 1'b0;
      step();
      chk("w_ack_drop", 16'(cpu_ack), 16'h0);

      // CPU read back 0x5000.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h5000;
      step();
      chk("r_we", 16'(mem_we), 16'h0);
      chk("r_ack_e0", 16'(cpu_ack), 16'h0);
      step();
      chk("r_ack_e1", 16'(cpu_ack), 16'h0);
      step();
      chk("r_ack_e2", 16'(cpu_ack), 16'h1);
      chk("r_rdata", 16'(cpu_rdata), 16'h003C);
      cpu_req = 1'b0;
      step();
      chk("r_ack_drop", 16'(cpu_ack), 16'h0);
      chk("r_rdata_hold", 16'(cpu_rdata), 16'h003C);

      // Blocked write below the protect limit.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1000; cpu_wdata = 8'h99;
      step();
      chk("wp_we_e0", 16'(mem_we), 16'h0);
      step();
      chk("wp_we_e1", 16'(mem_we), 16'h0);
      chk("wp_ack_e1", 16'(cpu_ack), 16'h0);
      step();
      chk("wp_ack", 16'(cpu_ack), 16'h1);
      chk("wp_err", 16'(cpu_wp_err), 16'h1);
      chk("wp_rdata_kept", 16'(cpu_rdata), 16'h003C);
      cpu_req = 1'b0;
      step();
      chk("wp_err_drop", 16'(cpu_wp_err), 16'h0);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1000;
      step(); step(); step();
      chk("wp_rb_ack", 16'(cpu_ack), 16'h1);
      chk("wp_rb_rdata", 16'(cpu_rdata), 16'h0077);
      chk("wp_rb_err", 16'(cpu_wp_err), 16'h0);
      cpu_req = 1'b0;
      step();

      // Video request the cycle after a CPU grant: 3-cycle latency, ack on time.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4800;
      step();
      vid_req = 1'b1; vid_addr = 16'h6000;
      step();
      vid_req = 1'b0;
      chk("mix_ack_e1", 16'(cpu_ack), 16'h0);
      step();
      chk("mix_ack", 16'(cpu_ack), 16'h1);
      chk("mix_rdata", 16'(cpu_rdata), 16'h00A5);
      chk("mix_vaddr", mem_addr, 16'h6000);
      cpu_req = 1'b0;
      step();
      chk("mix_valid_e2", 16'(vid_valid), 16'h0);
      step();
      chk("mix_valid_e3", 16'(vid_valid), 16'h1);
      chk("mix_vdata", 16'(vid_data), 16'h005A);
      chk("mix_overrun", 16'(vid_overrun), 16'h0);
      step();

      // Back-to-back video requests: pending then overrun.
      vid_req = 1'b1; vid_addr = 16'h4800;
      step();
      vid_addr = 16'h5000;
      step();
      chk("ov_e1_overrun", 16'(vid_overrun), 16'h0);
      chk("ov_e1_valid", 16'(vid_valid), 16'h0);
      vid_addr = 16'h6000;
      step();
      vid_req = 1'b0;
      chk("ov_e2_valid", 16'(vid_valid), 16'h1);
      chk("ov_e2_data", 16'(vid_data), 16'h00A5);
      chk("ov_e2_overrun", 16'(vid_overrun), 16'h1);
      chk("ov_e2_addr", mem_addr, 16'h6000);
      step();
      chk("ov_e3_valid", 16'(vid_valid), 16'h0);
      step();
      chk("ov_e4_valid", 16'(vid_valid), 16'h1);
      chk("ov_e4_data", 16'(vid_data), 16'h005A);
      step();
      chk("ov_e5_valid", 16'(vid_valid), 16'h0);
      step(); step(); step();
      chk("ov_sticky", 16'(vid_overrun), 16'h1);
      chk("ov_no_extra_valid", 16'(vid_valid), 16'h0);

      // Reset during S_CPU_WAIT of a read.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1000;
      step();
      step();
      rst_b = 1'b0;
      cpu_req = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      step();
      chk("rst_no_ack", 16'(cpu_ack), 16'h0);
      rst_b = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h5000;
      step();
      chk("post_ack_e0", 16'(cpu_ack), 16'h0);
      step();
      chk("post_ack_e1", 16'(cpu_ack), 16'h0);
      step();
      chk("post_ack", 16'(cpu_ack), 16'h1);
      chk("post_rdata", 16'(cpu_rdata), 16'h003C);
      chk("post_overrun", 16'(vid_overrun), 16'h0);
      cpu_req = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
